// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    CORE_PRI  = 2'd0,
    DBG_FORCE = 2'd1,
    DBG_LOCK  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  localparam int WAIT_W = 4;
  localparam int STAT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
    return (en && (v != {STAT_W{1'b1}})) ? v + STAT_W'(1) : v;
  endfunction

endpackage

// File: rtl/arb_wait_ctr.sv
// Saturating count of consecutive debug denials. reach flags the cycle whose
// denial brings the count up to MAX_WAIT, so the arbiter can switch state on
// that same edge.
module arb_wait_ctr
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clr,
  output logic [WAIT_W-1:0] cnt,
  output logic              reach
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise increment and hold at the top value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {WAIT_W{1'b1}})) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
    reach = inc && !clr && ((32'(cnt_q) + 32'd1) >= MAX_WAIT);
    cnt   = cnt_q;
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the single-port data memory.
// Core has priority; debug gets a starvation guard and an exclusive lock.
// Optional build macro DMEM_ARB_STATS_EN adds saturating grant/conflict counters.
// Handshake: a requester holds req/we/addr/wdata stable until it sees its gnt in
// the same cycle; a write commits on the edge ending the grant cycle; a read
// returns rdata with a one-cycle rvalid pulse on the following cycle.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [AW-1:0]     core_addr,
  input  logic [DW-1:0]     core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DW-1:0]     core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [AW-1:0]     dbg_addr,
  input  logic [DW-1:0]     dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DW-1:0]     dbg_rdata,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_we,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
`ifdef DMEM_ARB_STATS_EN
  output logic [STAT_W-1:0] stat_core_grants,
  output logic [STAT_W-1:0] stat_dbg_grants,
  output logic [STAT_W-1:0] stat_conflicts,
`endif
  output arb_state_t        fsm_state,
  output logic [WAIT_W-1:0] wait_cnt
);

  arb_state_t    state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [AW-1:0] addr_last_q, addr_last_d;
  logic [DW-1:0] core_rdata_q, core_rdata_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
  logic          wait_inc, wait_clr, wait_reach;

  arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait_ctr (
    .clk   (CLK),
    .rst   (Reset),
    .inc   (wait_inc),
    .clr   (wait_clr),
    .cnt   (wait_cnt),
    .reach (wait_reach)
  );

  // Grant decision from registered state and live requests; nothing granted in reset.
  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    if (!Reset) begin
      case (state_q)
        CORE_PRI: begin
          core_gnt = core_req;
          dbg_gnt  = dbg_req && !core_req;
        end
        DBG_FORCE: begin
          dbg_gnt  = dbg_req;
          core_gnt = core_req && !dbg_req;
        end
        DBG_LOCK: begin
          dbg_gnt  = dbg_req;
        end
        default: ;
      endcase
    end
  end

  // Memory port mux; the address parks on its last driven value when idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_last_q;
    mem_wdata = core_wdata;
    if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end
    addr_last_d = mem_addr;
  end

  // Next state, denial counting and read-return ownership.
  always_comb begin
    wait_inc = (state_q == CORE_PRI) && dbg_req && !dbg_gnt;
    wait_clr = dbg_lock || (state_q != CORE_PRI) || dbg_gnt;
    state_d  = state_q;
    if (dbg_lock) begin
      state_d = DBG_LOCK;
    end else begin
      case (state_q)
        CORE_PRI:  state_d = wait_reach ? DBG_FORCE : CORE_PRI;
        DBG_FORCE: state_d = CORE_PRI;
        DBG_LOCK:  state_d = CORE_PRI;
        default:   state_d = CORE_PRI;
      endcase
    end
    owner_d = OWN_NONE;
    if (dbg_gnt && !dbg_we) begin
      owner_d = OWN_DBG;
    end else if (core_gnt && !core_we) begin
      owner_d = OWN_CORE;
    end
  end

  // Read return: memory data passes through during rvalid, otherwise last value holds.
  always_comb begin
    core_rvalid  = (owner_q == OWN_CORE);
    dbg_rvalid   = (owner_q == OWN_DBG);
    core_rdata   = core_rvalid ? mem_rdata : core_rdata_q;
    dbg_rdata    = dbg_rvalid  ? mem_rdata : dbg_rdata_q;
    core_rdata_d = core_rdata;
    dbg_rdata_d  = dbg_rdata;
    fsm_state    = state_q;
  end

  // Arbiter state registers.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q      <= CORE_PRI;
      owner_q      <= OWN_NONE;
      addr_last_q  <= '0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_last_q  <= addr_last_d;
      core_rdata_q <= core_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] core_cnt_q, core_cnt_d;
  logic [STAT_W-1:0] dbg_cnt_q, dbg_cnt_d;
  logic [STAT_W-1:0] conf_cnt_q, conf_cnt_d;

  // Saturating usage counters.
  always_comb begin
    core_cnt_d       = sat_inc(core_cnt_q, core_gnt);
    dbg_cnt_d        = sat_inc(dbg_cnt_q, dbg_gnt);
    conf_cnt_d       = sat_inc(conf_cnt_q, core_req && dbg_req);
    stat_core_grants = core_cnt_q;
    stat_dbg_grants  = dbg_cnt_q;
    stat_conflicts   = conf_cnt_q;
  end

  // Counter registers.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      core_cnt_q <= '0;
      dbg_cnt_q  <= '0;
      conf_cnt_q <= '0;
    end else begin
      core_cnt_q <= core_cnt_d;
      dbg_cnt_q  <= dbg_cnt_d;
      conf_cnt_q <= conf_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic against a rule-level reference model and a reference memory image.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MAX_WAIT = 4;

  // clock / reset
  logic CLK = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  logic          core_req = 0, core_we = 0;
  logic [AW-1:0] core_addr = 0;
  logic [DW-1:0] core_wdata = 0;
  logic          core_gnt, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          dbg_req = 0, dbg_we = 0, dbg_lock = 0;
  logic [AW-1:0] dbg_addr = 0;
  logic [DW-1:0] dbg_wdata = 0;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  arb_state_t    fsm_state;
  logic [WAIT_W-1:0] wait_cnt;
`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] stat_core_grants, stat_dbg_grants, stat_conflicts;
`endif

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .CLK(CLK), .Reset(Reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef DMEM_ARB_STATS_EN
    .stat_core_grants(stat_core_grants), .stat_dbg_grants(stat_dbg_grants),
    .stat_conflicts(stat_conflicts),
`endif
    .fsm_state(fsm_state), .wait_cnt(wait_cnt)
  );

  // Second instance for the MAX_WAIT=1 boundary; memory side unused.
  logic          m1_core_req = 0, m1_dbg_req = 0;
  logic          m1_zero = 0;
  logic [AW-1:0] m1_addr = 0;
  logic [DW-1:0] m1_data = 0;
  logic          m1_core_gnt, m1_core_rvalid, m1_dbg_gnt, m1_dbg_rvalid, m1_mem_we;
  logic [DW-1:0] m1_core_rdata, m1_dbg_rdata, m1_mem_wdata;
  logic [AW-1:0] m1_mem_addr;
  arb_state_t    m1_state;
  logic [WAIT_W-1:0] m1_wait;
`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] m1_s0, m1_s1, m1_s2;
`endif

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(1)) dut_mw1 (
    .CLK(CLK), .Reset(Reset),
    .core_req(m1_core_req), .core_we(m1_zero), .core_addr(m1_addr), .core_wdata(m1_data),
    .core_gnt(m1_core_gnt), .core_rvalid(m1_core_rvalid), .core_rdata(m1_core_rdata),
    .dbg_req(m1_dbg_req), .dbg_we(m1_zero), .dbg_addr(m1_addr), .dbg_wdata(m1_data),
    .dbg_lock(m1_zero), .dbg_gnt(m1_dbg_gnt), .dbg_rvalid(m1_dbg_rvalid), .dbg_rdata(m1_dbg_rdata),
    .mem_addr(m1_mem_addr), .mem_we(m1_mem_we), .mem_wdata(m1_mem_wdata), .mem_rdata(m1_data),
`ifdef DMEM_ARB_STATS_EN
    .stat_core_grants(m1_s0), .stat_dbg_grants(m1_s1), .stat_conflicts(m1_s2),
`endif
    .fsm_state(m1_state), .wait_cnt(m1_wait)
  );

  // Synchronous-read data memory behind the arbiter.
  logic [DW-1:0] dmem [256];
  always @(posedge CLK) begin
    if (mem_we) dmem[mem_addr] <= mem_wdata;
    mem_rdata <= dmem[mem_addr];
  end

  // scoreboard state
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_q [$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs;
    core_req = 0; core_we = 0; dbg_req = 0; dbg_we = 0; dbg_lock = 0;
  endtask

  task automatic test_reset;
    Reset = 1;
    core_req = 1; core_we = 1; core_addr = 8'd3; core_wdata = 8'h11;
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'd3; dbg_wdata = 8'h22;
    @(negedge CLK);
    n_checks++; if (core_gnt !== 1'b0) $display("FAIL rst_core_gnt: got %b exp 0", core_gnt); else n_pass++;
    n_checks++; if (dbg_gnt !== 1'b0) $display("FAIL rst_dbg_gnt: got %b exp 0", dbg_gnt); else n_pass++;
    n_checks++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b exp 0", mem_we); else n_pass++;
    n_checks++; if ({core_rvalid, dbg_rvalid} !== 2'b00) $display("FAIL rst_rvalid: got %b exp 00", {core_rvalid, dbg_rvalid}); else n_pass++;
    n_checks++; if ({core_rdata, dbg_rdata} !== 16'h0) $display("FAIL rst_rdata: got %h exp 0000", {core_rdata, dbg_rdata}); else n_pass++;
    n_checks++; if (fsm_state !== CORE_PRI) $display("FAIL rst_state: got %0d exp %0d", fsm_state, CORE_PRI); else n_pass++;
    tick;
    Reset = 0;
    idle_inputs;
    @(negedge CLK);
    n_checks++; if ({core_gnt, dbg_gnt, mem_we, core_rvalid, dbg_rvalid} !== 5'b0) $display("FAIL idle_outputs: got %b exp 00000", {core_gnt, dbg_gnt, mem_we, core_rvalid, dbg_rvalid}); else n_pass++;
    n_checks++; if (wait_cnt !== 4'd0) $display("FAIL idle_wait_cnt: got %0d exp 0", wait_cnt); else n_pass++;
    tick;
  endtask

  // Fill the lower memory through the debug port so reads have known contents.
  task automatic test_preload;
    for (int a = 0; a < 64; a++) begin
      dbg_req = 1; dbg_we = 1; dbg_addr = AW'(a); dbg_wdata = DW'($urandom_range(0, 255));
      @(negedge CLK);
      n_checks++; if (dbg_gnt !== 1'b1 || mem_we !== 1'b1) $display("FAIL preload_gnt: got gnt=%b we=%b exp 1 1", dbg_gnt, mem_we); else n_pass++;
      ref_mem[a] = dbg_wdata;
      tick;
    end
    idle_inputs;
  endtask

  task automatic test_dbg_write_read;
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'd127; dbg_wdata = 8'hA5;
    @(negedge CLK);
    n_checks++; if (dbg_gnt !== 1'b1) $display("FAIL dbgwr_gnt: got %b exp 1", dbg_gnt); else n_pass++;
    n_checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'd127, 8'hA5}) $display("FAIL dbgwr_mem: got we=%b a=%0d d=%h exp 1 127 a5", mem_we, mem_addr, mem_wdata); else n_pass++;
    ref_mem[127] = 8'hA5;
    tick;
    dbg_we = 0;
    @(negedge CLK);
    n_checks++; if (dbg_gnt !== 1'b1 || mem_we !== 1'b0) $display("FAIL dbgrd_gnt: got gnt=%b we=%b exp 1 0", dbg_gnt, mem_we); else n_pass++;
    n_checks++; if (dbg_rvalid !== 1'b0) $display("FAIL dbgrd_early_rvalid: got %b exp 0", dbg_rvalid); else n_pass++;
    tick;
    idle_inputs;
    @(negedge CLK);
    n_checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 8'hA5) $display("FAIL dbgrd_data: got v=%b d=%h exp 1 a5", dbg_rvalid, dbg_rdata); else n_pass++;
    tick;
    @(negedge CLK);
    n_checks++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== 8'hA5) $display("FAIL dbgrd_hold: got v=%b d=%h exp 0 a5", dbg_rvalid, dbg_rdata); else n_pass++;
    n_checks++; if (mem_we !== 1'b0 || mem_addr !== 8'd127) $display("FAIL idle_park: got we=%b a=%0d exp 0 127", mem_we, mem_addr); else n_pass++;
    tick;
  endtask

  // Both sides request every cycle: debug must win every fifth cycle.
  task automatic test_starvation;
    logic prev_c, prev_d, exp_d;
    int exp_w;
    prev_c = 0; prev_d = 0;
    core_req = 1; core_we = 0; core_addr = 8'd10;
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'd20;
    for (int i = 0; i < 10; i++) begin
      exp_d = (i % (MAX_WAIT + 1)) == MAX_WAIT;
      exp_w = i % (MAX_WAIT + 1);
      @(negedge CLK);
      n_checks++; if ({core_gnt, dbg_gnt} !== {!exp_d, exp_d}) $display("FAIL starve_gnt cyc%0d: got c=%b d=%b exp c=%b d=%b", i, core_gnt, dbg_gnt, !exp_d, exp_d); else n_pass++;
      n_checks++; if (wait_cnt !== WAIT_W'(exp_w)) $display("FAIL starve_wait cyc%0d: got %0d exp %0d", i, wait_cnt, exp_w); else n_pass++;
      n_checks++; if (core_rvalid !== prev_c || (prev_c && core_rdata !== ref_mem[10])) $display("FAIL starve_core_rv cyc%0d: got v=%b d=%h exp v=%b d=%h", i, core_rvalid, core_rdata, prev_c, ref_mem[10]); else n_pass++;
      n_checks++; if (dbg_rvalid !== prev_d || (prev_d && dbg_rdata !== ref_mem[20])) $display("FAIL starve_dbg_rv cyc%0d: got v=%b d=%h exp v=%b d=%h", i, dbg_rvalid, dbg_rdata, prev_d, ref_mem[20]); else n_pass++;
      prev_c = !exp_d; prev_d = exp_d;
      tick;
    end
    idle_inputs;
    @(negedge CLK);
    n_checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== ref_mem[20]) $display("FAIL starve_last_rv: got v=%b d=%h exp 1 %h", dbg_rvalid, dbg_rdata, ref_mem[20]); else n_pass++;
    n_checks++; if (wait_cnt !== 4'd0) $display("FAIL starve_wait_end: got %0d exp 0", wait_cnt); else n_pass++;
    tick;
  endtask

  task automatic test_lock;
    // Lock rises while a core read is granted: that read still returns.
    core_req = 1; core_we = 0; core_addr = 8'd30; dbg_lock = 1;
    @(negedge CLK);
    n_checks++; if (core_gnt !== 1'b1) $display("FAIL lock_edge_core_gnt: got %b exp 1", core_gnt); else n_pass++;
    tick;
    core_addr = 8'd31;
    @(negedge CLK);
    n_checks++; if (core_gnt !== 1'b0) $display("FAIL lock_core_blocked: got %b exp 0", core_gnt); else n_pass++;
    n_checks++; if (core_rvalid !== 1'b1 || core_rdata !== ref_mem[30]) $display("FAIL lock_edge_rv: got v=%b d=%h exp 1 %h", core_rvalid, core_rdata, ref_mem[30]); else n_pass++;
    tick;
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'd4;
    @(negedge CLK);
    n_checks++; if ({core_gnt, dbg_gnt} !== 2'b01) $display("FAIL lock_rd4_gnt: got %b exp 01", {core_gnt, dbg_gnt}); else n_pass++;
    tick;
    dbg_addr = 8'd5;
    @(negedge CLK);
    n_checks++; if ({core_gnt, dbg_gnt} !== 2'b01) $display("FAIL lock_rd5_gnt: got %b exp 01", {core_gnt, dbg_gnt}); else n_pass++;
    n_checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== ref_mem[4]) $display("FAIL lock_rd4_data: got v=%b d=%h exp 1 %h", dbg_rvalid, dbg_rdata, ref_mem[4]); else n_pass++;
    tick;
    dbg_req = 0;
    @(negedge CLK);
    n_checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== ref_mem[5]) $display("FAIL lock_rd5_data: got v=%b d=%h exp 1 %h", dbg_rvalid, dbg_rdata, ref_mem[5]); else n_pass++;
    tick;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_checks++; if (core_gnt !== 1'b0) $display("FAIL lock_hold cyc%0d: got %b exp 0", i, core_gnt); else n_pass++;
      tick;
    end
    dbg_lock = 0;
    @(negedge CLK);
    n_checks++; if (core_gnt !== 1'b0) $display("FAIL unlock_same_cycle: got %b exp 0", core_gnt); else n_pass++;
    tick;
    @(negedge CLK);
    n_checks++; if (core_gnt !== 1'b1) $display("FAIL unlock_next_cycle: got %b exp 1", core_gnt); else n_pass++;
    tick;
    idle_inputs;
    @(negedge CLK);
    n_checks++; if (core_rvalid !== 1'b1 || core_rdata !== ref_mem[31]) $display("FAIL unlock_rd: got v=%b d=%h exp 1 %h", core_rvalid, core_rdata, ref_mem[31]); else n_pass++;
    tick;
  endtask

  task automatic test_reset_mid_txn;
    dbg_req = 1; dbg_we = 1; dbg_addr = 8'd50; dbg_wdata = 8'h3C;
    ref_mem[50] = 8'h3C;
    tick;
    idle_inputs;
    core_req = 1; core_we = 0; core_addr = 8'd50;
    @(negedge CLK);
    n_checks++; if (core_gnt !== 1'b1) $display("FAIL rstmid_rd_gnt: got %b exp 1", core_gnt); else n_pass++;
    tick;
    Reset = 1;
    core_we = 1; core_wdata = 8'hFF;
    @(negedge CLK);
    n_checks++; if (core_rvalid !== 1'b0 || core_rdata !== 8'h00) $display("FAIL rstmid_rv: got v=%b d=%h exp 0 00", core_rvalid, core_rdata); else n_pass++;
    n_checks++; if (mem_we !== 1'b0 || core_gnt !== 1'b0) $display("FAIL rstmid_write: got we=%b gnt=%b exp 0 0", mem_we, core_gnt); else n_pass++;
    tick;
    Reset = 0;
    core_we = 0;
    @(negedge CLK);
    n_checks++; if (core_gnt !== 1'b1) $display("FAIL rstmid_after_gnt: got %b exp 1", core_gnt); else n_pass++;
    tick;
    idle_inputs;
    @(negedge CLK);
    n_checks++; if (core_rvalid !== 1'b1 || core_rdata !== 8'h3C) $display("FAIL rstmid_after_data: got v=%b d=%h exp 1 3c", core_rvalid, core_rdata); else n_pass++;
    tick;
  endtask

  task automatic test_max_wait_one;
    logic exp_d;
    m1_core_req = 1; m1_dbg_req = 1;
    for (int i = 0; i < 4; i++) begin
      exp_d = (i % 2) == 1;
      @(negedge CLK);
      n_checks++; if ({m1_core_gnt, m1_dbg_gnt} !== {!exp_d, exp_d}) $display("FAIL mw1_gnt cyc%0d: got c=%b d=%b exp c=%b d=%b", i, m1_core_gnt, m1_dbg_gnt, !exp_d, exp_d); else n_pass++;
      tick;
    end
    m1_core_req = 0; m1_dbg_req = 0;
  endtask

  // Randomized traffic against a rule-level model of who may use the memory.
  task automatic test_random;
    bit m_locked;
    int m_den, lock_left;
    bit forced, e_core, e_dbg;
    bit exp_crv, exp_drv;
    logic [DW-1:0] held_c, held_d, want;
    Reset = 1; idle_inputs;
    tick;
    Reset = 0;
    m_locked = 0; m_den = 0; lock_left = 0;
    exp_crv = 0; exp_drv = 0; held_c = 0; held_d = 0;
    e_core = 0; e_dbg = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!(core_req && !e_core)) begin
        core_req = $urandom_range(0, 99) < 60;
        core_we = $urandom_range(0, 1) == 1;
        core_addr = AW'($urandom_range(0, 15));
        core_wdata = DW'($urandom_range(0, 255));
      end
      if (!(dbg_req && !e_dbg)) begin
        dbg_req = $urandom_range(0, 99) < 50;
        dbg_we = $urandom_range(0, 1) == 1;
        dbg_addr = AW'($urandom_range(0, 15));
        dbg_wdata = DW'($urandom_range(0, 255));
      end
      if (lock_left > 0) begin
        lock_left--;
        dbg_lock = 1;
      end else if ($urandom_range(0, 99) < 4) begin
        lock_left = $urandom_range(1, 5);
        dbg_lock = 1;
      end else begin
        dbg_lock = 0;
      end
      forced = !m_locked && (m_den >= MAX_WAIT);
      if (m_locked) begin
        e_core = 0; e_dbg = dbg_req;
      end else if (forced) begin
        e_dbg = dbg_req; e_core = core_req && !dbg_req;
      end else begin
        e_core = core_req; e_dbg = dbg_req && !core_req;
      end
      @(negedge CLK);
      n_checks++; if ({core_gnt, dbg_gnt} !== {e_core, e_dbg}) $display("FAIL rand_gnt cyc%0d: got c=%b d=%b exp c=%b d=%b", cyc, core_gnt, dbg_gnt, e_core, e_dbg); else n_pass++;
      want = exp_crv ? exp_q.pop_front() : held_c;
      n_checks++; if (core_rvalid !== exp_crv || core_rdata !== want) $display("FAIL rand_core_rd cyc%0d: got v=%b d=%h exp v=%b d=%h", cyc, core_rvalid, core_rdata, exp_crv, want); else n_pass++;
      held_c = want;
      want = exp_drv ? exp_q.pop_front() : held_d;
      n_checks++; if (dbg_rvalid !== exp_drv || dbg_rdata !== want) $display("FAIL rand_dbg_rd cyc%0d: got v=%b d=%h exp v=%b d=%h", cyc, dbg_rvalid, dbg_rdata, exp_drv, want); else n_pass++;
      held_d = want;
      exp_crv = e_core && !core_we;
      exp_drv = e_dbg && !dbg_we;
      if (exp_crv) exp_q.push_back(ref_mem[core_addr]);
      if (exp_drv) exp_q.push_back(ref_mem[dbg_addr]);
      if (e_core && core_we) ref_mem[core_addr] = core_wdata;
      if (e_dbg && dbg_we) ref_mem[dbg_addr] = dbg_wdata;
      if (dbg_lock) begin
        m_locked = 1; m_den = 0;
      end else begin
        if (m_locked || forced || e_dbg) m_den = 0;
        else if (dbg_req) m_den++;
        m_locked = 0;
      end
      tick;
    end
    idle_inputs;
    tick;
    exp_q.delete();
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats;
    Reset = 1; idle_inputs;
    tick;
    Reset = 0;
    core_req = 1; core_we = 0; core_addr = 8'd1;
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'd2;
    repeat (10) tick;
    idle_inputs;
    tick;
    @(negedge CLK);
    n_checks++; if (stat_conflicts !== 16'd10) $display("FAIL stat_conflicts: got %0d exp 10", stat_conflicts); else n_pass++;
    n_checks++; if (stat_core_grants + stat_dbg_grants !== 16'd10) $display("FAIL stat_sum: got %0d exp 10", stat_core_grants + stat_dbg_grants); else n_pass++;
    n_checks++; if (stat_dbg_grants !== 16'd2) $display("FAIL stat_dbg: got %0d exp 2", stat_dbg_grants); else n_pass++;
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_preload;
    test_dbg_write_read;
    test_starvation;
    test_lock;
    test_reset_mid_txn;
    test_max_wait_one;
    test_random;
`ifdef DMEM_ARB_STATS_EN
    test_stats;
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between two requesters: the processor core's load/store path and a debug/loader port. The debug port is used by benches and loaders for preload and for result readback, e.g. the result location at address 127. The core has priority by default. The debug port has a starvation guard and a lock mode that freezes the core out of memory. The block sits between the core's memory stage and the data memory instance inside the top level.

Parameters:
AW, 8, address width (256-byte data memory)
DW, 8, data width
MAX_WAIT, 4, consecutive denied debug cycles before debug is forced to win; legal range 1..15

Ports:
CLK  in  1  clock, all state updates on rising edge
Reset  in  1  asynchronous, active-high reset
core_req  in  1  core access request
core_we  in  1  1=write, 0=read
core_addr  in  AW  core address
core_wdata  in  DW  core write data
core_gnt  out  1  core access accepted this cycle; core stalls while core_req && !core_gnt
core_rvalid  out  1  core read data valid
core_rdata  out  DW  core read data
dbg_req  in  1  debug access request
dbg_we  in  1  1=write, 0=read
dbg_addr  in  AW  debug address
dbg_wdata  in  DW  debug write data
dbg_lock  in  1  request exclusive memory ownership for debug
dbg_gnt  out  1  debug access accepted this cycle
dbg_rvalid  out  1  debug read data valid
dbg_rdata  out  DW  debug read data
mem_addr  out  AW  memory address
mem_we  out  1  memory write enable
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  synchronous-read memory output, one cycle after address

Behaviour:
Reset:
- Reset asserted: state=CORE_PRI, wait_cnt=0, rvalid owner cleared.
- core_rvalid=0, dbg_rvalid=0, core_rdata=0, dbg_rdata=0.
- Grants are combinational and are 0 while Reset is high. mem_we=0 while Reset is high.
- Reset mid-transaction drops any pending rvalid. No write commits in a cycle where Reset is high.

Handshake:
- A requester holds req, we, addr and wdata stable until it sees gnt.
- At most one gnt per cycle.
- Write: commits at the rising edge that ends the grant cycle.
- Read: data appears next cycle on rdata with rvalid=1 for one cycle. rdata outside rvalid is held at its last value.
- Zero-wait back-to-back grants are allowed.

Mux:
- mem_addr, mem_we and mem_wdata come from the granted requester.
- With no grant: mem_we=0, mem_addr=last driven value.

FSM (registered state; grant is combinational from state and requests):
- CORE_PRI: core wins on conflict; otherwise the lone requester wins.
  - A cycle with dbg_req && !dbg_gnt increments wait_cnt.
  - wait_cnt reaching MAX_WAIT moves to DBG_FORCE.
  - Any dbg grant clears wait_cnt.
- DBG_FORCE: debug wins on conflict. After the debug grant, go to CORE_PRI and set wait_cnt=0. If dbg_req drops before it is granted, go to CORE_PRI.
- DBG_LOCK: entered from any state at the edge where dbg_lock=1.
  - core_gnt=0 always in this state; debug is granted whenever it requests.
  - dbg_lock=0 returns the block to CORE_PRI with wait_cnt=0.
- A core read granted in the cycle lock rises still returns its rvalid the next cycle.

Boundaries:
- MAX_WAIT=1: debug is forced after the first denial.
- Same-cycle write and read to the same address from different owners is impossible, because only one grant is issued per cycle.

Optional Feature:
DMEM_ARB_STATS_EN:
- Defined: adds outputs stat_core_grants[15:0], stat_dbg_grants[15:0] and stat_conflicts[15:0].
  - These are saturating counters, reset to 0.
  - stat_conflicts counts cycles where core_req && dbg_req.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - the arb_state_t enum {CORE_PRI, DBG_FORCE, DBG_LOCK};
  - the owner_t enum {OWN_NONE, OWN_CORE, OWN_DBG};
  - localparam WAIT_W=4;
  - localparam STAT_W=16.
- One sub-module, arb_wait_ctr: a saturating denial counter with clear and a threshold-reached flag.

Test Plan:
- Reset then idle: all gnt, rvalid and mem_we are 0; rdata=0.
- Debug write 8'hA5 to addr 127, then debug read of 127 → dbg_gnt on the request cycle; dbg_rvalid=1 one cycle after the read grant with dbg_rdata=8'hA5.
- Core and debug both request every cycle, MAX_WAIT=4 → core granted 4 cycles, debug granted on the 5th, core granted on the 6th; wait_cnt returns to 0.
- dbg_lock=1 while core_req is held high → core_gnt stays 0 for the whole lock; debug reads of addr 4 and 5 succeed; on unlock, core_gnt=1 the next cycle.
- Reset asserted the cycle after a core read grant → core_rvalid stays 0 and nothing is written; after release, a core read of the same address returns the correct data.
- With DMEM_ARB_STATS_EN and 10 conflict cycles → stat_conflicts=10 and stat_core_grants + stat_dbg_grants = total grants issued.
